// File: rtl/alu_muldiv_sequencer.sv
// Iterative 32x32 unsigned MULTU/DIVU sequencer driving an external ALU_32.
// Optional MULDIV_EARLY_EXIT_EN: multiply finishes once remaining multiplier bits are zero.
`timescale 1ns/1ps
module alu_muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_opnd;
   logic [CNT_W-1:0] r_cnt;
   logic             r_div;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz;
`ifdef MULDIV_EARLY_EXIT_EN
   logic [WIDTH-1:0]   r_shadow;
   logic [2*WIDTH-1:0] w_shr;
   logic               w_exit;
`endif

   logic             w_run;
   logic             w_last;
   logic [WIDTH-1:0] w_r;
   logic [WIDTH-1:0] w_nhi;
   logic [WIDTH-1:0] w_nlo;

   assign w_run  = (r_state == S_RUN);
   assign w_last = (r_cnt == CNT_W'(WIDTH-1));
   assign w_r    = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};

   assign alu_a  = w_run ? (r_div ? w_r : r_hi) : '0;
   assign alu_b  = w_run ? r_opnd : '0;
   assign alu_op = w_run ? (r_div ? 4'b0110 : 4'b0010) : 4'b0000;

   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign hi          = r_hi;
   assign lo          = r_lo;

   // Carry out of the add is the 65th product bit, shifted into hi[MSB].
   always_comb begin
      w_nhi = r_hi;
      w_nlo = r_lo;
      if (r_div) begin
         if (r_hi[WIDTH-1] | alu_cout) begin
            w_nhi = alu_result;
            w_nlo = {r_lo[WIDTH-2:0], 1'b1};
         end else begin
            w_nhi = w_r;
            w_nlo = {r_lo[WIDTH-2:0], 1'b0};
         end
      end else if (r_lo[0]) begin
         {w_nhi, w_nlo} = {alu_cout, alu_result, r_lo[WIDTH-1:1]};
      end else begin
         {w_nhi, w_nlo} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
      end
   end

`ifdef MULDIV_EARLY_EXIT_EN
   assign w_shr  = {r_hi, r_lo} >> (CNT_W'(WIDTH) - r_cnt);
   assign w_exit = ~r_div & (r_shadow == '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opnd   <= '0;
         r_cnt    <= '0;
         r_div    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
         r_shadow <= '0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (op_div && (src_b == '0)) begin
                     r_hi    <= src_a;
                     r_lo    <= '1;
                     r_dbz   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_hi     <= '0;
                     r_lo     <= op_div ? src_a : src_b;
                     r_opnd   <= op_div ? src_b : src_a;
                     r_cnt    <= '0;
                     r_div    <= op_div;
                     r_dbz    <= 1'b0;
                     r_busy   <= 1'b1;
                     r_state  <= S_RUN;
`ifdef MULDIV_EARLY_EXIT_EN
                     r_shadow <= src_b;
`endif
                  end
               end
            end
            S_RUN: begin
`ifdef MULDIV_EARLY_EXIT_EN
               if (w_exit) begin
                  {r_hi, r_lo} <= w_shr;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
                  r_state      <= S_DONE;
               end else begin
                  r_hi     <= w_nhi;
                  r_lo     <= w_nlo;
                  r_cnt    <= r_cnt + CNT_W'(1);
                  r_shadow <= r_shadow >> 1;
                  if (w_last) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
`else
               r_hi  <= w_nhi;
               r_lo  <= w_nlo;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
`endif
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Scoreboard bench for alu_muldiv_sequencer with a behavioural ALU_32 model.
`timescale 1ns/1ps
module tb_alu_muldiv_sequencer;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         op_div = 1'b0;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo, alu_a, alu_b, alu_result;
   logic [3:0]   alu_op;
   logic         alu_cout;
   logic [W:0]   alu_sum;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           lat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // ALU_32: {ainv, binv, op}; binv also supplies carry-in.
   assign alu_sum = {1'b0, (alu_op[3] ? ~alu_a : alu_a)}
                  + {1'b0, (alu_op[2] ? ~alu_b : alu_b)}
                  + {{W{1'b0}}, alu_op[2]};
   assign alu_result = alu_sum[W-1:0];
   assign alu_cout   = alu_sum[W];

   alu_muldiv_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div),
      .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_cout(alu_cout)
   );

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic div);
      exp_t e;
      logic [2*W-1:0] p;
      int n;
      e.dbz = 1'b0;
      e.lat = W + 1;
      if (div && b == '0) begin
         e.hi = a; e.lo = '1; e.dbz = 1'b1; e.lat = 1;
      end else if (div) begin
         e.lo = a / b; e.hi = a % b;
      end else begin
         p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
         e.hi = p[2*W-1:W]; e.lo = p[W-1:0];
         n = 0;
         for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
`ifdef MULDIV_EARLY_EXIT_EN
         e.lat = (n >= W) ? W + 1 : n + 2;
`endif
      end
      return e;
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic div, input int glitch);
      exp_t e;
      exp_t f;
      int cyc;
      bit seen;
      sb.push_back(model(a, b, div));
      f = sb[0];
      @(posedge clk); #1;
      start = 1'b1; op_div = div; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0; op_div = 1'($urandom); src_a = $urandom; src_b = $urandom;
      cyc = 1; seen = 0;
      while (!seen && cyc <= W + 5) begin
         checks++;
         if (busy !== (cyc < f.lat && !f.dbz)) begin
            errors++;
            $display("FAIL busy a=%h b=%h cyc=%0d got %b want %b", a, b, cyc, busy,
                     (cyc < f.lat && !f.dbz));
         end
         if (cyc == 1 && !f.dbz) begin
            checks++;
            if (alu_op !== (div ? 4'b0110 : 4'b0010) || div_by_zero !== 1'b0) begin
               errors++;
               $display("FAIL run_start alu_op/dbz got %h/%b want %h/0", alu_op,
                        div_by_zero, (div ? 4'b0110 : 4'b0010));
            end
         end
         start = (cyc == glitch);
         if (done) begin
            seen = 1;
            e = sb.pop_front();
            checks++;
            if (cyc !== e.lat || hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz) begin
               errors++;
               $display("FAIL result a=%h b=%h div=%b got lat=%0d hi=%h lo=%h dbz=%b want lat=%0d hi=%h lo=%h dbz=%b",
                        a, b, div, cyc, hi, lo, div_by_zero, e.lat, e.hi, e.lo, e.dbz);
            end
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      start = 1'b0;
      if (!seen) begin
         checks++; errors++;
         $display("FAIL timeout a=%h b=%h got no done want done by %0d", a, b, f.lat);
         if (sb.size() > 0) void'(sb.pop_front());
      end else begin
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || hi !== e.hi || lo !== e.lo) begin
               errors++;
               $display("FAIL hold k=%0d got done=%b hi=%h lo=%h want 0 %h %h",
                        k, done, hi, lo, e.hi, e.lo);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 0 || done !== 0 || div_by_zero !== 0 || hi !== 0 || lo !== 0 ||
          alu_op !== 0 || alu_a !== 0 || alu_b !== 0) begin
         errors++;
         $display("FAIL reset got busy=%b done=%b dbz=%b hi=%h lo=%h op=%h want all 0",
                  busy, done, div_by_zero, hi, lo, alu_op);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mul();
      run_op(32'd7, 32'd6, 1'b0, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      run_op(32'h8000_0001, 32'h8000_0000, 1'b0, 0);
      for (int i = 0; i < 3; i++) run_op($urandom, $urandom, 1'b0, 0);
   endtask

   task automatic test_div();
      run_op(32'd100, 32'd7, 1'b1, 0);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 0);
      run_op(32'd5, 32'hFFFF_FFFF, 1'b1, 0);
      run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
      for (int i = 0; i < 3; i++) run_op($urandom, $urandom_range(1, 32'hFFFF), 1'b1, 0);
   endtask

   task automatic test_div_by_zero();
      run_op(32'h1234_5678, 32'd0, 1'b1, 0);
      run_op(32'd9, 32'd3, 1'b1, 0);
   endtask

   task automatic test_start_ignored();
      run_op(32'd7, 32'd6, 1'b0, 10);
      run_op(32'd1000, 32'd0, 1'b1, 0);
      run_op(32'd3, 32'd4, 1'b0, 0);
   endtask

   task automatic test_early_exit();
      run_op(32'd5, 32'd1, 1'b0, 0);
      run_op(32'hDEAD_BEEF, 32'd0, 1'b0, 0);
      run_op(32'hFFFF_FFFF, 32'h0000_0100, 1'b0, 0);
   endtask

   task automatic test_reset_abort();
      bit bad;
      @(posedge clk); #1;
      start = 1'b1; op_div = 1'b1; src_a = 32'd1000; src_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 15; c++) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre busy got %b want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 0 || done !== 0 || hi !== 0 || lo !== 0) begin
         errors++;
         $display("FAIL abort got busy=%b done=%b hi=%h lo=%h want 0", busy, done, hi, lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) bad = 1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL abort_post got done/busy after reset want none");
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_by_zero();
      test_start_ignored();
      test_early_exit();
      test_reset_abort();
      run_op(32'd12, 32'd12, 1'b0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
